cla_word_sequencer: RTL and testbench
=====================================

Name: cla_word_sequencer

Overview:
- Byte-serial multi-precision add/subtract stage. Accepts operand bytes LSB-first over a valid/ready stream and feeds each byte pair through an 8-bit carry-lookahead slice.
- Chains the carry between bytes in a register.
- Emits registered sum bytes on a valid/ready output stream, with end-of-word carry and signed-overflow flags.
- Sits between the operand input pins and the result output pins. It extends the existing 8-bit CLA datapath to WORDS-byte operands.

Parameters:
- WORDS, 4, bytes per operand word. Legal range 1..16.
- IDXW, derived as max(1, clog2(WORDS)), width of the byte index counter. Not user-overridable.

Ports:
- clk  in  1  Clock. The only clock.
- rst_n  in  1  Reset, synchronous, active-low.
- flush  in  1  Abandons the partial word. Clears the byte index and the carry register.
- in_valid  in  1  Input byte pair valid.
- in_ready  out  1  Stage can accept an input byte pair.
- in_a  in  8  Operand A byte.
- in_b  in  8  Operand B byte.
- in_cin  in  1  Carry-in. Sampled only on byte 0 of an add.
- in_sub  in  1  1 = A − B. Sampled only on byte 0 and held for the whole word.
- out_valid  out  1  Output byte valid.
- out_ready  in  1  Consumer accepts the output byte.
- out_sum  out  8  Sum or difference byte.
- out_last  out  1  Output byte is byte WORDS−1 of the word.
- out_cout  out  1  Final carry-out (for subtract, 1 = no borrow). Valid only when out_last=1, otherwise 0.
- out_ovf  out  1  Signed overflow of the word. Valid only when out_last=1, otherwise 0.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following, and dominates all other inputs:
  - out_valid, out_sum, out_last, out_cout, out_ovf → 0.
  - Byte index idx → 0, carry_q → 0, sub_q → 0.
- in_ready = !flush && (!out_valid || out_ready). This is a single output register with pass-through throughput: one byte per cycle when out_ready=1.
- accept = in_valid && in_ready.
- Effective operands for the slice:
  - sub_eff = (idx==0) ? in_sub : sub_q.
  - b_eff = sub_eff ? ~in_b : in_b.
  - c_eff = (idx==0) ? (in_sub ? 1 : in_cin) : carry_q.
- On accept:
  - out_sum ← slice sum of (in_a, b_eff, c_eff); out_valid ← 1.
  - carry_q ← slice cout.
  - If idx==0: sub_q ← in_sub.
  - If idx==WORDS−1: out_last ← 1, out_cout ← slice cout, out_ovf ← slice c7 XOR slice cout, idx ← 0.
  - Otherwise: out_last, out_cout, out_ovf ← 0 and idx ← idx+1.
- No accept and out_ready=1: out_valid ← 0. The data registers hold their values.
- Latency: one clk from input accept to out_valid.
- Output stability: out_* remain stable while out_valid=1 and out_ready=0.
- WORDS=1: every byte is both first and last, and carry_q is never consumed.
- flush=1: idx ← 0, carry_q ← 0. in_ready is forced to 0, so flush and accept never coincide. The output register is untouched, so a pending output byte is still delivered.
- Reset mid-word: the partial word is discarded and any pending output is dropped. The first byte accepted after reset is byte 0.
- in_cin is ignored on subtract and on bytes 1..WORDS−1.

Decomposition:
- Shared package holds:
  - localparam BYTE_W = 8.
  - The function computing IDXW.
  - The typedef for the byte-pair payload struct {a, b, cin, sub}.
- One sub-module, cla8_slice. It is purely combinational, with inputs a[7:0], b[7:0], cin and outputs sum[7:0], c7 (carry into bit 7), cout.
  - Implements full 8-bit generate/propagate lookahead.
  - It is the only arithmetic in the block.
- The sequencer itself is counter, carry register, sub latch and output register. Expected size is about 150 lines including the slice.

Test Plan (all cases WORDS=4, bytes LSB-first, out_ready=1 unless stated):
- Add 0x000000FF+0x00000001, cin=0: pairs (FF,01),(00,00)×3 → out_sum 00,01,00,00. last=1 on the 4th byte, cout=0, ovf=0.
- Add 0xFFFFFFFF+0x00000001: out_sum 00,00,00,00 → cout=1, ovf=0.
- Add 0x7FFFFFFF+0x00000000 with cin=1 on byte 0 → sums 00,00,00,80, cout=0, ovf=1.
- Subtract, in_sub=1 on byte 0 only:
  - 0x00000000−0x00000001 → FF,FF,FF,FF, cout=0, ovf=0.
  - 0x80000000−0x00000001 → FF,FF,FF,7F, cout=1, ovf=1.
- Backpressure: drive 4 bytes back-to-back with out_ready=0 after the first output → in_ready=0 and out_sum stable for 5 cycles. Release → the remaining 3 bytes complete on consecutive cycles with correct carry chaining.
- Flush and reset: after 2 bytes of 0xFF+0x01, pulse flush → a pending output is still delivered, in_ready=0 during flush. The next word 0x00000002+0x00000003 yields 05,00,00,00 with last on its 4th byte. Assert rst_n=0 with out_valid=1 → out_valid=0 next cycle, and the following byte is treated as byte 0.

Source files
------------

// File: rtl/cla_word_sequencer_pkg.sv
// Shared definitions for the byte-serial multi-precision add/subtract stage.
//   BYTE_W     : width of one operand slice (one byte).
//   bytePair_t : one input beat, the A/B operand bytes plus carry-in and subtract flag.
//   calcIdxw   : width of the byte index counter for a given word length.
package cla_word_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef struct packed {
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
        logic              cin;
        logic              sub;
    } bytePair_t;

    // A one-byte word still needs a one-bit counter so the index register
    // never collapses to zero width.
    function automatic int calcIdxw(input int words);
        if (words <= 2) begin
            return 1;
        end
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cla_word_sequencer_cla8_slice.sv
// Purely combinational 8-bit carry-lookahead adder slice.
//   a, b  : operand bytes
//   cin   : carry into bit 0
//   sum   : a + b + cin, low 8 bits
//   c7    : carry into bit 7, used with cout to detect signed overflow
//   cout  : carry out of bit 7
module cla8_slice
    import cla_word_sequencer_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              c7,
    output logic              cout
);

    logic [BYTE_W-1:0] w_g;
    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is formed directly from the generate/propagate terms and
    // cin as a flat sum of products, so no carry waits on the carry below it.
    always_comb begin
        logic term;
        term   = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & w_p[k];
            end
            w_c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | term;
            end
        end
    end

    assign sum  = w_p ^ w_c[BYTE_W-1:0];
    assign c7   = w_c[BYTE_W-1];
    assign cout = w_c[BYTE_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// Byte-serial multi-precision add/subtract stage. Operand bytes arrive
// LSB-first; each pair goes through one 8-bit CLA slice, with the carry
// chained between bytes in a register. Results leave through a single
// registered output stage.
//   clk, rst_n          : clock and synchronous active-low reset
//   flush               : abandon the partial word (index and carry cleared)
//   in_valid/in_ready   : input byte-pair handshake
//   in_a, in_b          : operand bytes
//   in_cin, in_sub      : carry-in and subtract select, sampled on byte 0 only
//   out_valid/out_ready : output byte handshake
//   out_sum             : result byte
//   out_last            : result byte is the last byte of the word
//   out_cout, out_ovf   : word carry-out and signed overflow, only on the last byte
module cla_word_sequencer
    import cla_word_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int              IDXW     = calcIdxw(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_sub;
    logic              r_outValid;
    logic [BYTE_W-1:0] r_outSum;
    logic              r_outLast;
    logic              r_outCout;
    logic              r_outOvf;

    bytePair_t         w_pair;
    logic              w_first;
    logic              w_last;
    logic              w_subEff;
    logic [BYTE_W-1:0] w_bEff;
    logic              w_cEff;
    logic              w_accept;
    logic [BYTE_W-1:0] w_sliceSum;
    logic              w_sliceC7;
    logic              w_sliceCout;

    assign w_pair = '{a: in_a, b: in_b, cin: in_cin, sub: in_sub};

    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == LAST_IDX);

    // Subtraction is A + ~B + 1: byte 0 injects the +1 itself, later bytes
    // keep inverting B under the latched mode and chain the stored carry.
    assign w_subEff = w_first ? w_pair.sub : r_sub;
    assign w_bEff   = w_subEff ? ~w_pair.b : w_pair.b;
    assign w_cEff   = w_first ? (w_pair.sub | w_pair.cin) : r_carry;

    // The output register may be refilled in the same cycle it is drained;
    // flush blocks input so a flush never coincides with an accept.
    assign in_ready = !flush && (!r_outValid || out_ready);
    assign w_accept = in_valid && in_ready;

    cla8_slice u_slice (
        .a    (w_pair.a),
        .b    (w_bEff),
        .cin  (w_cEff),
        .sum  (w_sliceSum),
        .c7   (w_sliceC7),
        .cout (w_sliceCout)
    );

    // Byte counter, carry chain, subtract latch and output register.
    // Flush only touches the word state, so a pending output still drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_outValid <= 1'b0;
            r_outSum   <= '0;
            r_outLast  <= 1'b0;
            r_outCout  <= 1'b0;
            r_outOvf   <= 1'b0;
        end else begin
            if (flush) begin
                r_idx   <= '0;
                r_carry <= 1'b0;
            end
            if (w_accept) begin
                r_outValid <= 1'b1;
                r_outSum   <= w_sliceSum;
                r_carry    <= w_sliceCout;
                if (w_first) begin
                    r_sub <= w_pair.sub;
                end
                if (w_last) begin
                    r_outLast <= 1'b1;
                    r_outCout <= w_sliceCout;
                    r_outOvf  <= w_sliceC7 ^ w_sliceCout;
                    r_idx     <= '0;
                end else begin
                    r_outLast <= 1'b0;
                    r_outCout <= 1'b0;
                    r_outOvf  <= 1'b0;
                    r_idx     <= r_idx + IDXW'(1);
                end
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_sum   = r_outSum;
    assign out_last  = r_outLast;
    assign out_cout  = r_outCout;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer (WORDS=4). A word-level
// arithmetic model predicts every output byte when its input is accepted;
// a monitor compares the presented output against the queue head.
module tb_cla_word_sequencer;

    localparam int WORDS = 4;
    localparam int WBITS = 8 * WORDS;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    bit   randReady = 1'b0;

    int          byteIdx = 0;
    logic        wSub;
    logic        wCin;
    logic [63:0] accA;
    logic [63:0] accB;
    logic [63:0] bEff;
    logic [63:0] mask;
    logic [63:0] total;
    exp_t        e;

    cla_word_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Output check, then the reference model. The model works on whole words:
    // the operand prefix received so far is added with plain integer arithmetic
    // and the current result byte, carry and overflow are read off the total.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_output: got sum 0x%0h, expected no output", out_sum);
            end else begin
                checkOutput("out_byte {sum,last,cout,ovf}",
                            32'({out_sum, out_last, out_cout, out_ovf}),
                            32'({expQ[0].sum, expQ[0].last, expQ[0].cout, expQ[0].ovf}));
                if (out_ready === 1'b1) begin
                    void'(expQ.pop_front());
                end
            end
        end
        if (rst_n !== 1'b1) begin
            expQ.delete();
            byteIdx = 0;
        end else begin
            if (flush === 1'b1) begin
                byteIdx = 0;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                if (byteIdx == 0) begin
                    wSub = in_sub;
                    wCin = in_cin;
                    accA = '0;
                    accB = '0;
                end
                accA  = accA | (64'(in_a) << (8 * byteIdx));
                accB  = accB | (64'(in_b) << (8 * byteIdx));
                mask  = (64'd1 << (8 * (byteIdx + 1))) - 64'd1;
                bEff  = wSub ? (~accB & mask) : accB;
                total = accA + bEff + (wSub ? 64'd1 : 64'(wCin));
                e.sum  = 8'(total >> (8 * byteIdx));
                e.last = (byteIdx == WORDS - 1);
                e.cout = e.last ? total[WBITS] : 1'b0;
                e.ovf  = e.last ? ((accA[WBITS-1] == bEff[WBITS-1]) && (total[WBITS-1] != accA[WBITS-1])) : 1'b0;
                expQ.push_back(e);
                byteIdx = e.last ? 0 : byteIdx + 1;
            end
        end
    end

    // Random consumer backpressure, only while enabled.
    always @(posedge clk) begin
        if (randReady) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        int waitCnt = 0;
        bit taken = 1'b0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        while (!taken && waitCnt < 200) begin
            @(negedge clk);
            taken = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            waitCnt++;
        end
        in_valid = 1'b0;
        if (!taken) begin
            nChecks++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waitCnt);
        end
    endtask

    // Bytes 1..WORDS-1 carry random cin/sub, which the stage must ignore.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub, input int nBytes);
        for (int k = 0; k < nBytes; k++) begin
            sendByte(a[8*k +: 8], b[8*k +: 8],
                     (k == 0) ? cin : 1'($urandom),
                     (k == 0) ? sub : 1'($urandom));
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        idle(3);
        checkOutput("reset_outputs", 32'({out_valid, out_sum, out_last, out_cout, out_ovf}), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        idle(1);

        // Directed add/subtract words.
        applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, WORDS);
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, WORDS);
        applyStimulus(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, WORDS);
        applyStimulus(32'h00000000, 32'h00000001, 1'b0, 1'b1, WORDS);
        applyStimulus(32'h80000000, 32'h00000001, 1'b1, 1'b1, WORDS);
        idle(3);

        // Backpressure: first output held for several cycles while input stalls.
        out_ready = 1'b0;
        fork
            applyStimulus(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, WORDS);
            begin
                n = 0;
                while (out_valid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) begin
                    nChecks++;
                    $display("[TB] FAIL stall_valid_timeout: out_valid stayed 0, expected 1");
                end
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Flush after two bytes with the second result still pending.
        applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 2);
        out_ready = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush_pending_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(2);
        applyStimulus(32'h00000002, 32'h00000003, 1'b0, 1'b0, WORDS);
        idle(3);

        // Reset mid-word with an output pending.
        out_ready = 1'b0;
        sendByte(8'h5A, 8'hC3, 1'b1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_drop_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus($urandom, $urandom, 1'($urandom), 1'b0, WORDS);
        idle(3);

        // Randomized words, random backpressure and occasional flushed partial words.
        randReady = 1'b1;
        for (int w = 0; w < 30; w++) begin
            if (($urandom % 5) == 0) begin
                applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom), 1 + int'($urandom % (WORDS - 1)));
                flush = 1'b1;
                idle(1);
                flush = 1'b0;
            end else begin
                applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom), WORDS);
            end
            idle(int'($urandom % 3));
        end
        randReady = 1'b0;
        idle(1);
        out_ready = 1'b1;

        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
